demux_1to4_sched: RTL and testbench
===================================

Name: demux_1to4_sched

Overview:
- Sequential scheduler around the 1-to-4, 8-bit demux datapath: accepts a valid/ready input stream and distributes each word to one of four output channels.
- Channel choice is either round-robin (pointer-driven) or addressed (per-word destination field).
- Each channel has a one-deep output register, so a stalled consumer blocks only its own channel.
- Sits between a single producer and four independent consumers; also drives the demux select.

Parameters:
- WIDTH, 8, data width of input and each output channel.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  input word.
- in_valid  input  1  input word present.
- in_ready  output  1  scheduler accepts the word this cycle.
- mode  input  1  0 = round-robin, 1 = addressed.
- dest  input  2  target channel when mode=1; ignored when mode=0.
- o0, o1, o2, o3  output  WIDTH each  channel data; all-zero when the channel is not valid.
- out_valid  output  4  bit k = channel k holds a word.
- out_ready  input  4  bit k = consumer k takes the word this cycle.
- cur_sel  output  2  target channel for the current cycle (demux select).
- busy  output  1  OR of out_valid.

Behaviour:
- Reset (async assert, sync-safe deassert): out_valid=0, o0..o3=0, RR pointer=0, cur_sel=0, busy=0. Reset mid-operation discards all buffered words with no partial output.
- Target: tgt = dest if mode=1, else RR pointer. cur_sel = tgt (combinational).
- Drain: channel k fires when out_valid[k] & out_ready[k]. On fire, out_valid[k] clears next edge unless it is refilled the same cycle.
- in_ready = ~out_valid[tgt] | out_ready[tgt]. It is combinational from out_ready, mode and dest. A full channel with simultaneous drain accepts (pass-through, no bubble).
- Accept = in_valid & in_ready:
  - Next edge: channel tgt register ← in_data and out_valid[tgt]=1.
  - Latency is 1 cycle from accept to out_valid.
- RR pointer:
  - Advances by 1 mod 4 (3→0 wrap) only on an accept with mode=0.
  - Holds when mode=1. The value is retained across mode changes.
- RR stall: if the pointer's channel is full and not draining, in_ready=0. No skipping to other channels; strict order is preserved.
- Addressed mode: words to distinct non-full channels are accepted back-to-back, one per cycle.
- mode/dest are sampled only with in_valid. A change while in_valid=0 has no effect on state.
- Outputs o_k are registered values gated to zero when out_valid[k]=0.
- Data on a channel is stable while out_valid[k]=1 and out_ready[k]=0.
- in_valid=0: no state change except drains.

Optional Feature:
- Macro DEMUX_SCHED_CNT_EN.
- Defined:
  - Adds output ports acc_cnt (16 bits, wrapping count of accepted words) and stall_cnt (16 bits, saturating at 16'hFFFF, counts cycles with in_valid=1 and in_ready=0).
  - Both counters reset to 0 on rst_n.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: drive rst_n=0 mid-stream with channels 1 and 2 full → out_valid=4'b0000, o0..o3=0, cur_sel=0 asynchronously; after release the first RR word goes to channel 0.
- RR sweep: mode=0, out_ready=4'hF, words 8'h11,22,33,44,55 on consecutive cycles → o0=11, o1=22, o2=33, o3=44, then o0=55 (wrap). in_ready stays 1 throughout.
- RR stall: mode=0, out_ready=4'b1110, 5 words → words 1-4 go to channels 0-3, then in_ready=0 (pointer=0, channel 0 full). Raising out_ready[0] accepts word 5 the same cycle; o0=word5 next edge.
- Addressed: mode=1, dest sequence 2,2,0 with out_ready[2]=0 → first word to channel 2, second stalls (in_ready=0). Third is not presented until the stall clears; order is preserved; the RR pointer is unchanged.
- Pass-through: channel 3 full with out_ready[3]=1 and an accept with dest=3 in the same cycle → in_ready=1, out_valid[3] stays 1, o3 updates to the new word with no bubble.
- With DEMUX_SCHED_CNT_EN: run the RR stall case → acc_cnt=5, stall_cnt equals the number of cycles with in_valid=1 and in_ready=0. Force 70000 accepts → acc_cnt wraps to 4464.

Source files
------------

// File: rtl/demux_1to4_sched.sv
// rtl/demux_1to4_sched.sv - 1-to-4 demux scheduler with per-channel one-deep output registers
//
// Purpose:
//   Distributes words from a single valid/ready producer onto four independent
//   channels.
//   - mode=0 (round-robin): a pointer selects the channel in strict order.
//   - mode=1 (addressed): the per-word dest field selects the channel.
//   Each channel holds at most one word, so a stalled consumer blocks only its
//   own channel (or, in round-robin mode, the pointer while it sits on that
//   channel).
//
// Optional feature (macro DEMUX_SCHED_CNT_EN):
//   Adds the acc_cnt and stall_cnt ports and their counters.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_data    in   [WIDTH] input word
//   in_valid   in   input word present
//   in_ready   out  word accepted this cycle when in_valid is also high
//   mode       in   0 = round-robin, 1 = addressed
//   dest       in   [2] target channel in addressed mode
//   o0..o3     out  [WIDTH] channel data, zero while the channel is empty
//   out_valid  out  [4] channel k holds a word
//   out_ready  in   [4] consumer k takes its word this cycle
//   cur_sel    out  [2] target channel this cycle (demux select)
//   busy       out  any channel holds a word
//   acc_cnt    out  [16] wrapping count of accepted words (DEMUX_SCHED_CNT_EN only)
//   stall_cnt  out  [16] saturating count of stalled input cycles (DEMUX_SCHED_CNT_EN only)
module demux_1to4_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [1:0]       dest,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [1:0]       cur_sel,
  output logic             busy
`ifdef DEMUX_SCHED_CNT_EN
  ,
  output logic [15:0]      acc_cnt,
  output logic [15:0]      stall_cnt
`endif
);

  logic [1:0]       rr_ptr;
  logic [3:0]       vld;
  logic [WIDTH-1:0] data_q [4];

  logic [1:0]       tgt;
  logic             accept;
  logic [3:0]       fire;
  logic [3:0]       load;

  always_comb begin
    tgt = rr_ptr;
    if (mode) tgt = dest;
  end

  // A full channel that is draining this cycle still accepts, which gives
  // pass-through with no bubble.
  assign in_ready = ~vld[tgt] | out_ready[tgt];
  assign accept   = in_valid & in_ready;
  assign fire     = vld & out_ready;

  always_comb begin
    load = 4'b0000;
    if (accept) load[tgt] = 1'b1;
  end

  // Refill wins over drain, so a channel that fires and loads in the same
  // cycle stays valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= 4'b0000;
      rr_ptr <= 2'd0;
    end else begin
      vld <= (vld & ~fire) | load;
      if (accept && !mode) rr_ptr <= rr_ptr + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load[k]) data_q[k] <= in_data;
      end
    end
  end

  // The select is forced to zero while reset is held, so it reads 0 even if
  // addressed mode is being driven.
  assign cur_sel   = rst_n ? tgt : 2'd0;
  assign out_valid = vld;
  assign busy      = |vld;
  assign o0        = vld[0] ? data_q[0] : '0;
  assign o1        = vld[1] ? data_q[1] : '0;
  assign o2        = vld[2] ? data_q[2] : '0;
  assign o3        = vld[3] ? data_q[3] : '0;

`ifdef DEMUX_SCHED_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt   <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (accept) acc_cnt <= acc_cnt + 16'd1;
      if (in_valid && !in_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_1to4_sched.sv
// tb/tb_demux_1to4_sched.sv - self-checking bench for demux_1to4_sched
module tb_demux_1to4_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       mode = 1'b0;
  logic [1:0] dest = 2'd0;
  logic [7:0] o0, o1, o2, o3;
  logic [3:0] out_valid;
  logic [3:0] out_ready = 4'h0;
  logic [1:0] cur_sel;
  logic       busy;
`ifdef DEMUX_SCHED_CNT_EN
  logic [15:0] acc_cnt, stall_cnt;
`endif

  demux_1to4_sched #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .dest(dest),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3),
    .out_valid(out_valid), .out_ready(out_ready), .cur_sel(cur_sel), .busy(busy)
`ifdef DEMUX_SCHED_CNT_EN
    , .acc_cnt(acc_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel is a queue of at most one word; the round-robin
  // pointer is a plain integer modulo 4.
  logic [7:0] mq [4][$];
  int         mrr = 0;
  int         m_acc = 0;
  int         m_stall = 0;
  logic [7:0] oview [4];
  assign oview[0] = o0;
  assign oview[1] = o1;
  assign oview[2] = o2;
  assign oview[3] = o3;

  always @(negedge clk) begin
    int  t;
    bit  exp_ready;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) mq[k].delete();
      mrr = 0; m_acc = 0; m_stall = 0;
      chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
      chk("rst_cur_sel", {30'd0, cur_sel}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      for (int k = 0; k < 4; k++) chk("rst_data", {24'd0, oview[k]}, 32'd0);
    end else begin
      t = mode ? int'(dest) : mrr;
      exp_ready = (mq[t].size() == 0) || out_ready[t];
      chk("cur_sel", {30'd0, cur_sel}, t);
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      for (int k = 0; k < 4; k++) begin
        chk("out_valid", {31'd0, out_valid[k]}, (mq[k].size() != 0) ? 32'd1 : 32'd0);
        chk("odata", {24'd0, oview[k]}, (mq[k].size() != 0) ? {24'd0, mq[k][0]} : 32'd0);
      end
      chk("busy", {31'd0, busy},
          (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() != 0) ? 32'd1 : 32'd0);
`ifdef DEMUX_SCHED_CNT_EN
      chk("acc_cnt", {16'd0, acc_cnt}, m_acc % 65536);
      chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
`endif
      // Advance the model to the state after the coming rising edge.
      for (int k = 0; k < 4; k++)
        if (mq[k].size() != 0 && out_ready[k]) void'(mq[k].pop_front());
      if (in_valid && exp_ready) begin
        mq[t].push_back(in_data);
        if (!mode) mrr = (mrr + 1) % 4;
        m_acc++;
      end
      if (in_valid && !exp_ready && m_stall < 65535) m_stall++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic m, input logic [1:0] de);
    in_data = d; mode = m; dest = de; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        step();
        in_valid = 1'b0;
        return;
      end
      step();
    end
    chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    rst_n = 1'b1;
    step();

    // Round-robin sweep with all consumers ready; 55 wraps to channel 0.
    out_ready = 4'hF;
    send(8'h11, 1'b0, 2'd3); chk("rr_o0", {24'd0, o0}, 32'h11);
    send(8'h22, 1'b0, 2'd3); chk("rr_o1", {24'd0, o1}, 32'h22);
    send(8'h33, 1'b0, 2'd0); chk("rr_o2", {24'd0, o2}, 32'h33);
    send(8'h44, 1'b0, 2'd1); chk("rr_o3", {24'd0, o3}, 32'h44);
    send(8'h55, 1'b0, 2'd2); chk("rr_wrap_o0", {24'd0, o0}, 32'h55);
    step();

    // Fill channels 1 and 2, then reset mid-stream.
    out_ready = 4'h0;
    send(8'hAA, 1'b1, 2'd1);
    send(8'hBB, 1'b1, 2'd2);
    chk("pre_rst_valid", {28'd0, out_valid}, 32'h6);
    mode = 1'b1; dest = 2'd3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {28'd0, out_valid}, 32'h0);
    chk("async_rst_o1", {24'd0, o1}, 32'h0);
    chk("async_rst_cur_sel", {30'd0, cur_sel}, 32'h0);
    step(); step();
    mode = 1'b0;
    rst_n = 1'b1;
    step();

    // Round-robin stall on channel 0.
    out_ready = 4'b1110;
    send(8'h01, 1'b0, 2'd0); chk("post_rst_ch0", {28'd0, out_valid}, 32'h1);
    send(8'h02, 1'b0, 2'd0);
    send(8'h03, 1'b0, 2'd0);
    send(8'h04, 1'b0, 2'd0);
    chk("stall_valid", {28'd0, out_valid}, 32'h9);
    chk("stall_o0", {24'd0, o0}, 32'h01);
    in_data = 8'h05; in_valid = 1'b1;
    @(negedge clk); chk("stall_ready0", {31'd0, in_ready}, 32'd0); step();
    @(negedge clk); chk("stall_ready1", {31'd0, in_ready}, 32'd0); step();
    out_ready = 4'hF;
    @(negedge clk); chk("stall_release", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("stall_o0_word5", {24'd0, o0}, 32'h05);
`ifdef DEMUX_SCHED_CNT_EN
    chk("lit_acc_cnt", {16'd0, acc_cnt}, 32'd5);
    chk("lit_stall_cnt", {16'd0, stall_cnt}, 32'd2);
`endif
    step();

    // Addressed mode with channel 2 blocked; pointer sits at 1.
    out_ready = 4'b1011;
    send(8'hA1, 1'b1, 2'd2);
    in_data = 8'hA2; dest = 2'd2; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("addr_stall", {31'd0, in_ready}, 32'd0); step();
    end
    out_ready = 4'b1111;
    @(negedge clk); chk("addr_release", {31'd0, in_ready}, 32'd1); step();
    in_valid = 1'b0;
    chk("addr_o2", {24'd0, o2}, 32'hA2);
    send(8'hA3, 1'b1, 2'd0);
    chk("addr_o0", {24'd0, o0}, 32'hA3);
    mode = 1'b0; dest = 2'd3;
    #1; chk("rr_ptr_held", {30'd0, cur_sel}, 32'd1);
    step();

    // Pass-through on channel 3 plus back-to-back addressed words.
    out_ready = 4'h0;
    send(8'hC1, 1'b1, 2'd3);
    out_ready = 4'b1000;
    send(8'hC2, 1'b1, 2'd3);
    chk("pt_valid3", {31'd0, out_valid[3]}, 32'd1);
    chk("pt_o3", {24'd0, o3}, 32'hC2);
    send(8'hD0, 1'b1, 2'd0);
    send(8'hD1, 1'b1, 2'd1);
    send(8'hD2, 1'b1, 2'd2);
    chk("b2b_valid", {28'd0, out_valid}, 32'h7);
    out_ready = 4'hF;
    step(); step();

`ifdef DEMUX_SCHED_CNT_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mode = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      in_data = i[7:0];
      step();
    end
    in_valid = 1'b0;
    chk("acc_wrap", {16'd0, acc_cnt}, 32'd4464);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
